trap_sequencer: RTL and testbench



---
 rtl/trap_sequencer.sv | 168 ++++++++++++++++
 tb/tb_trap_sequencer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/trap_sequencer.sv
// Machine-mode trap/return sequencer: stalls the core, walks the mepc/mcause/mstatus
// writes through the single CSR write port, then redirects the PC.
module trap_sequencer #(
  parameter int unsigned VECTORED = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        exception,
  input  logic [30:0] excCode,
  input  logic        irq,
  input  logic [30:0] irqCode,
  input  logic        mret,
  input  logic [31:0] pc,
  input  logic [31:0] mstatus,
  input  logic [31:0] mtvec,
  input  logic [31:0] mepc,
  output logic        stall,
  output logic        csrWrEn,
  output logic [11:0] csrAddr,
  output logic [31:0] csrWdata,
  output logic        pcLoad,
  output logic [31:0] pcTarget,
  output logic        busy
);

  localparam int unsigned XLEN   = 32;
  localparam int unsigned CODE_W = 31;
  localparam int unsigned CSR_AW = 12;

  localparam logic [CSR_AW-1:0] CSR_MSTATUS = 12'h300;
  localparam logic [CSR_AW-1:0] CSR_MEPC    = 12'h341;
  localparam logic [CSR_AW-1:0] CSR_MCAUSE  = 12'h342;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_EPC,
    S_WR_CAUSE,
    S_WR_STATUS,
    S_MRET_STATUS,
    S_REDIRECT
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [XLEN-1:0]     r_epc;
  logic [CODE_W-1:0]   r_code;
  logic                r_is_irq;
  logic                r_is_mret;

  logic                w_take_mret;
  logic                w_take_irq;
  logic                w_req;
  logic                w_accept;
  logic [XLEN-1:0]     w_status_trap;
  logic [XLEN-1:0]     w_status_mret;
  logic [XLEN-1:0]     w_tvec_base;
  logic [XLEN-1:0]     w_vec_target;
  logic [XLEN-1:0]     w_mepc_base;
  logic                w_use_vector;

  // Priority: exception > mret > enabled irq; reset masks acceptance so stall drops too
  assign w_take_mret = !exception && mret;
  assign w_take_irq  = !exception && !mret && irq && mstatus[3];
  assign w_req       = exception || mret || (irq && mstatus[3]);
  assign w_accept    = rst_n && (r_state == S_IDLE) && w_req;

  always_comb begin
    w_status_trap        = mstatus;
    w_status_trap[7]     = mstatus[3];
    w_status_trap[3]     = 1'b0;
    w_status_trap[12:11] = 2'b11;
    w_status_mret        = mstatus;
    w_status_mret[3]     = mstatus[7];
    w_status_mret[7]     = 1'b1;
    w_status_mret[12:11] = 2'b11;
  end

  assign w_tvec_base  = mtvec & ~XLEN'(3);
  assign w_mepc_base  = mepc & ~XLEN'(3);
  assign w_vec_target = w_tvec_base + {r_code[29:0], 2'b00};
  assign w_use_vector = (VECTORED != 0) && r_is_irq && (mtvec[1:0] == 2'b01);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Request context captured once on acceptance; held for the whole sequence
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_epc     <= '0;
      r_code    <= '0;
      r_is_irq  <= 1'b0;
      r_is_mret <= 1'b0;
    end else if (r_state == S_IDLE && w_req) begin
      r_epc     <= pc;
      r_code    <= exception ? excCode : irqCode;
      r_is_irq  <= w_take_irq;
      r_is_mret <= w_take_mret;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = (r_state != S_IDLE);
    stall       = 1'b0;
    csrWrEn     = 1'b0;
    csrAddr     = '0;
    csrWdata    = '0;
    pcLoad      = 1'b0;
    pcTarget    = '0;
    case (r_state)
      S_IDLE: begin
        stall = w_accept;
        if (w_accept) begin
          w_state_nxt = w_take_mret ? S_MRET_STATUS : S_WR_EPC;
        end
      end
      S_WR_EPC: begin
        stall       = 1'b1;
        csrWrEn     = 1'b1;
        csrAddr     = CSR_MEPC;
        csrWdata    = r_epc;
        w_state_nxt = S_WR_CAUSE;
      end
      S_WR_CAUSE: begin
        stall       = 1'b1;
        csrWrEn     = 1'b1;
        csrAddr     = CSR_MCAUSE;
        csrWdata    = {r_is_irq, r_code};
        w_state_nxt = S_WR_STATUS;
      end
      S_WR_STATUS: begin
        stall       = 1'b1;
        csrWrEn     = 1'b1;
        csrAddr     = CSR_MSTATUS;
        csrWdata    = w_status_trap;
        w_state_nxt = S_REDIRECT;
      end
      S_MRET_STATUS: begin
        stall       = 1'b1;
        csrWrEn     = 1'b1;
        csrAddr     = CSR_MSTATUS;
        csrWdata    = w_status_mret;
        w_state_nxt = S_REDIRECT;
      end
      S_REDIRECT: begin
        stall       = 1'b1;
        pcLoad      = 1'b1;
        if (r_is_mret) begin
          pcTarget = w_mepc_base;
        end else if (w_use_vector) begin
          pcTarget = w_vec_target;
        end else begin
          pcTarget = w_tvec_base;
        end
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_trap_sequencer.sv
// Scoreboard bench for trap_sequencer: stimulus pushes cycle-stamped expected CSR
// writes and PC redirects; a negedge monitor pops and compares them.
module tb_trap_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        exception;
  logic [30:0] excCode;
  logic        irq;
  logic [30:0] irqCode;
  logic        mret;
  logic [31:0] pc;
  logic [31:0] mstatus;
  logic [31:0] mtvec;
  logic [31:0] mepc;
  logic        stall, csrWrEn, pcLoad, busy;
  logic [11:0] csrAddr;
  logic [31:0] csrWdata, pcTarget;
  logic        nv_stall, nv_csrWrEn, nv_pcLoad, nv_busy;
  logic [11:0] nv_csrAddr;
  logic [31:0] nv_csrWdata, nv_pcTarget;

  always #5 clk = ~clk;

  trap_sequencer #(.VECTORED(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .exception(exception), .excCode(excCode),
    .irq(irq), .irqCode(irqCode), .mret(mret), .pc(pc), .mstatus(mstatus),
    .mtvec(mtvec), .mepc(mepc), .stall(stall), .csrWrEn(csrWrEn),
    .csrAddr(csrAddr), .csrWdata(csrWdata), .pcLoad(pcLoad),
    .pcTarget(pcTarget), .busy(busy)
  );

  trap_sequencer #(.VECTORED(0)) u_dut_nv (
    .clk(clk), .rst_n(rst_n), .exception(exception), .excCode(excCode),
    .irq(irq), .irqCode(irqCode), .mret(mret), .pc(pc), .mstatus(mstatus),
    .mtvec(mtvec), .mepc(mepc), .stall(nv_stall), .csrWrEn(nv_csrWrEn),
    .csrAddr(nv_csrAddr), .csrWdata(nv_csrWdata), .pcLoad(nv_pcLoad),
    .pcTarget(nv_pcTarget), .busy(nv_busy)
  );

  typedef struct {
    int          cyc;
    bit          is_pc;
    logic [11:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t q[$];
  exp_t qn[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=event required=none (cycle %0d)", name, cyc);
  endtask

  // Monitor: every CSR write and PC redirect must match the head of its queue
  always @(negedge clk) begin
    exp_t e;
    if (csrWrEn) begin
      if (q.size() == 0) flag("csr_write_unexpected");
      else begin
        e = q.pop_front();
        chk("csr_kind", 32'(e.is_pc), 32'd0);
        chk("csr_cycle", 32'(cyc), 32'(e.cyc));
        chk("csr_addr", 32'(csrAddr), 32'(e.addr));
        chk("csr_wdata", csrWdata, e.data);
      end
    end else begin
      chk("csr_addr_idle", 32'(csrAddr), 32'd0);
      chk("csr_wdata_idle", csrWdata, 32'd0);
    end
    if (pcLoad) begin
      if (q.size() == 0) flag("pcload_unexpected");
      else begin
        e = q.pop_front();
        chk("pc_kind", 32'(e.is_pc), 32'd1);
        chk("pc_cycle", 32'(cyc), 32'(e.cyc));
        chk("pc_target", pcTarget, e.data);
      end
    end
    if (nv_pcLoad) begin
      if (qn.size() == 0) flag("nv_pcload_unexpected");
      else begin
        e = qn.pop_front();
        chk("nv_pc_cycle", 32'(cyc), 32'(e.cyc));
        chk("nv_pc_target", nv_pcTarget, e.data);
      end
    end
  end

  task automatic push(input int c, input bit is_pc, input logic [11:0] a, input logic [31:0] d);
    exp_t e;
    e.cyc = c; e.is_pc = is_pc; e.addr = a; e.data = d;
    q.push_back(e);
  endtask

  task automatic push_nv(input int c, input logic [31:0] d);
    exp_t e;
    e.cyc = c; e.is_pc = 1'b1; e.addr = '0; e.data = d;
    qn.push_back(e);
  endtask

  task automatic do_trap(input logic exc, input logic mr, input logic iq,
                         input logic [30:0] ecode, input logic [30:0] icode,
                         input logic [31:0] pcv, input logic [31:0] ms, input logic [31:0] tv,
                         input logic [31:0] exp_cause, input logic [31:0] exp_status,
                         input logic [31:0] exp_tgt, input logic [31:0] exp_tgt_nv);
    int t0;
    @(posedge clk); #1;
    exception = exc; mret = mr; irq = iq; excCode = ecode; irqCode = icode;
    pc = pcv; mstatus = ms; mtvec = tv;
    t0 = cyc;
    push(t0 + 1, 1'b0, 12'h341, pcv);
    push(t0 + 2, 1'b0, 12'h342, exp_cause);
    push(t0 + 3, 1'b0, 12'h300, exp_status);
    push(t0 + 4, 1'b1, 12'h000, exp_tgt);
    push_nv(t0 + 4, exp_tgt_nv);
    #1;
    chk("trap_t0_stall", 32'(stall), 32'd1);
    chk("trap_t0_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    exception = 1'b0; mret = 1'b0; irq = 1'b0; pc = 32'hDEAD_BEE0;
    repeat (4) @(posedge clk);
    #1;
    chk("trap_t5_busy", 32'(busy), 32'd0);
    chk("trap_t5_stall", 32'(stall), 32'd0);
  endtask

  task automatic do_mret(input logic [31:0] ms, input logic [31:0] ep,
                         input logic [31:0] exp_status, input logic [31:0] exp_tgt);
    int t0;
    @(posedge clk); #1;
    mret = 1'b1; mstatus = ms; mepc = ep;
    t0 = cyc;
    push(t0 + 1, 1'b0, 12'h300, exp_status);
    push(t0 + 2, 1'b1, 12'h000, exp_tgt);
    push_nv(t0 + 2, exp_tgt);
    #1;
    chk("mret_t0_stall", 32'(stall), 32'd1);
    @(posedge clk); #1;
    mret = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("mret_t3_busy", 32'(busy), 32'd0);
    chk("mret_t3_stall", 32'(stall), 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_stall"}, 32'(stall), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_csrWrEn"}, 32'(csrWrEn), 32'd0);
    chk({tag, "_csrAddr"}, 32'(csrAddr), 32'd0);
    chk({tag, "_csrWdata"}, csrWdata, 32'd0);
    chk({tag, "_pcLoad"}, 32'(pcLoad), 32'd0);
    chk({tag, "_pcTarget"}, pcTarget, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; exception = 1'b0; excCode = '0; irq = 1'b0; irqCode = '0;
    mret = 1'b0; pc = '0; mstatus = '0; mtvec = '0; mepc = '0;
    #1;
    chk_all_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // ECALL, direct mode
    do_trap(1'b1, 1'b0, 1'b0, 31'd11, 31'd0, 32'h100, 32'h8, 32'h200,
            32'h0000_000B, 32'h1880, 32'h200, 32'h200);
    // Vectored interrupt; non-vectored instance goes to base
    do_trap(1'b0, 1'b0, 1'b1, 31'd0, 31'd7, 32'h180, 32'h8, 32'h201,
            32'h8000_0007, 32'h1880, 32'h21C, 32'h200);

    // Masked interrupt must never be accepted
    irq = 1'b1; irqCode = 31'd3; mstatus = 32'h0;
    repeat (10) begin
      #1;
      chk("masked_stall", 32'(stall), 32'd0);
      chk("masked_busy", 32'(busy), 32'd0);
      chk("masked_csrWrEn", 32'(csrWrEn), 32'd0);
      chk("masked_pcLoad", 32'(pcLoad), 32'd0);
      @(posedge clk); #1;
    end
    irq = 1'b0;

    // Exception wins over mret and enabled irq; exception cause never vectors
    do_trap(1'b1, 1'b1, 1'b1, 31'd2, 31'd5, 32'h300, 32'h8, 32'h201,
            32'h0000_0002, 32'h1880, 32'h200, 32'h200);
    do_mret(32'h1880, 32'h107, 32'h1888, 32'h104);
    do_mret(32'h0000_0000, 32'h2000_0002, 32'h0000_1880, 32'h2000_0000);
    // All-ones mstatus and max code, direct mode with low bits set
    do_trap(1'b1, 1'b0, 1'b0, 31'h7FFF_FFFF, 31'd0, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'hFFFF_FFFD,
            32'h7FFF_FFFF, 32'hFFFF_FFF7, 32'hFFFF_FFFC, 32'hFFFF_FFFC);
    // Vectored target wraps mod 2^32; code bit 30 dropped from offset
    do_trap(1'b0, 1'b0, 1'b1, 31'd0, 31'h7FFF_FFFF, 32'h40, 32'h8, 32'hFFFF_FF01,
            32'hFFFF_FFFF, 32'h1880, 32'hFFFF_FEFC, 32'hFFFF_FF00);

    // Reset in WR_CAUSE: outputs drop at once, then a clean replay
    @(posedge clk); #1;
    exception = 1'b1; excCode = 31'd3; pc = 32'h400; mstatus = 32'h8; mtvec = 32'h200;
    push(cyc + 1, 1'b0, 12'h341, 32'h400);
    @(posedge clk);
    @(posedge clk); #1;
    chk("pre_reset_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    repeat (2) @(posedge clk);
    #1 exception = 1'b0; rst_n = 1'b1;
    #1;
    chk("post_reset_busy", 32'(busy), 32'd0);
    chk("post_reset_stall", 32'(stall), 32'd0);
    do_trap(1'b1, 1'b0, 1'b0, 31'd3, 31'd0, 32'h400, 32'h8, 32'h200,
            32'h0000_0003, 32'h1880, 32'h200, 32'h200);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_left", 32'(q.size()), 32'd0);
    chk("sb_nv_left", 32'(qn.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
